pool_scheduler: RTL



---
 rtl/pool_scheduler.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pool_scheduler.sv
// pool_scheduler: round sequencer for the hashing pool.
// Loads a job's nonce base, pulses all cores in lock-step, checks the
// per-core match vector after each round and advances the base by
// POOL_SIZE until a match is found or the nonce space carries out.
// Optional feature macro: POOL_SCHED_WATCHDOG_EN (WAIT-state watchdog).
module pool_scheduler #(
    parameter int unsigned POOL_SIZE       = 2,
    parameter int unsigned POOL_SIZE_LOG2  = 1,
    parameter int unsigned NONCE_WIDTH     = 32,
    parameter int unsigned WATCHDOG_CYCLES = 1024
) (
    input  logic                      clk_in,
    input  logic                      reset_n_in,
    input  logic                      job_valid_in,
    input  logic [NONCE_WIDTH-1:0]    nonce_start_in,
    input  logic                      halt_in,
    input  logic [POOL_SIZE-1:0]      core_done_in,
    input  logic [POOL_SIZE-1:0]      core_match_in,
    output logic                      core_start_out,
    output logic [NONCE_WIDTH-1:0]    nonce_base_out,
    output logic [NONCE_WIDTH-1:0]    winner_nonce_out,
    output logic [POOL_SIZE_LOG2-1:0] winner_idx_out,
    output logic                      found_out,
    output logic                      exhausted_out,
    output logic                      busy_out,
    output logic                      ready_out,
    output logic                      fault_out
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT      = 3'd2;
    localparam logic [2:0] S_CHECK     = 3'd3;
    localparam logic [2:0] S_FOUND     = 3'd4;
    localparam logic [2:0] S_EXHAUSTED = 3'd5;
    localparam logic [2:0] S_FAULT     = 3'd6;

    // Elaboration-time sanity check of the configuration
    if (POOL_SIZE_LOG2 < 1 || POOL_SIZE > (1 << POOL_SIZE_LOG2) ||
        POOL_SIZE < 1 || WATCHDOG_CYCLES < 2) begin : g_bad_params
        $error("pool_scheduler: inconsistent parameters");
    end

    logic [2:0]                state_q, state_d;
    logic [NONCE_WIDTH-1:0]    base_q, base_d;
    logic [POOL_SIZE-1:0]      match_q, match_d;
    logic [NONCE_WIDTH-1:0]    win_nonce_q, win_nonce_d;
    logic [POOL_SIZE_LOG2-1:0] win_idx_q, win_idx_d;
    logic [POOL_SIZE_LOG2-1:0] low_idx;
    logic [NONCE_WIDTH:0]      base_sum;
    logic                      core_start_q, busy_q, found_q, exhausted_q, ready_q;
    logic                      wd_expired;

    // Next base with carry out; the carry alone marks nonce-space exhaustion
    assign base_sum = {1'b0, base_q} + (NONCE_WIDTH+1)'(POOL_SIZE);

`ifdef POOL_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES);

    logic [WD_W-1:0] wd_cnt_q;
    logic            fault_q;

    // Watchdog counter: zero on entry to WAIT, counts every WAIT cycle
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wd_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_q <= '0;
        end
    end

    assign wd_expired = (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1));

    // Fault flag register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign fault_out = fault_q;
`else
    assign wd_expired = 1'b0;
    assign fault_out  = 1'b0;
`endif

    // Lowest set index of the latched match vector
    always_comb begin
        low_idx = '0;
        for (int i = int'(POOL_SIZE) - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                low_idx = POOL_SIZE_LOG2'(i);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            match_q     <= '0;
            win_nonce_q <= '0;
            win_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            match_q     <= match_d;
            win_nonce_q <= win_nonce_d;
            win_idx_q   <= win_idx_d;
        end
    end

    // Next-state and datapath update; halt beats job reload, both beat the round
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        match_d     = match_q;
        win_nonce_d = win_nonce_q;
        win_idx_d   = win_idx_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (&core_done_in) begin
                    match_d = core_match_in;
                    state_d = S_CHECK;
                end else if (wd_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_CHECK: begin
                if (|match_q) begin
                    win_idx_d   = low_idx;
                    win_nonce_d = base_q + NONCE_WIDTH'(low_idx);
                    state_d     = S_FOUND;
                end else if (base_sum[NONCE_WIDTH]) begin
                    state_d = S_EXHAUSTED;
                end else begin
                    base_d  = base_sum[NONCE_WIDTH-1:0];
                    state_d = S_START;
                end
            end
            S_FOUND, S_EXHAUSTED, S_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (halt_in) begin
            state_d     = S_IDLE;
            base_d      = base_q;
            win_nonce_d = win_nonce_q;
            win_idx_d   = win_idx_q;
        end else if (job_valid_in) begin
            state_d     = S_START;
            base_d      = nonce_start_in;
            win_nonce_d = win_nonce_q;
            win_idx_d   = win_idx_q;
        end
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            core_start_q <= (state_d == S_START);
            busy_q       <= (state_d == S_START) || (state_d == S_WAIT) ||
                            (state_d == S_CHECK);
            found_q      <= (state_d == S_FOUND);
            exhausted_q  <= (state_d == S_EXHAUSTED);
            ready_q      <= (state_d == S_FOUND) || (state_d == S_EXHAUSTED) ||
                            (state_d == S_FAULT);
        end
    end

    assign core_start_out   = core_start_q;
    assign busy_out         = busy_q;
    assign found_out        = found_q;
    assign exhausted_out    = exhausted_q;
    assign ready_out        = ready_q;
    assign nonce_base_out   = base_q;
    assign winner_nonce_out = win_nonce_q;
    assign winner_idx_out   = win_idx_q;

endmodule
